// File: rtl/gfx_fixed_dot_seq.sv
// gfx_fixed_dot_seq: LANES-wide fixed-point dot product issued lane by lane through one shared FMA.
// Define GFX_DOT_BIAS_EN to seed the accumulator with in_bias at accept.
`ifndef FIXED_FMA_STAGES
`define FIXED_FMA_STAGES 5
`endif
module gfx_fixed_dot_seq #(
    parameter int LANES  = 4,
    parameter int STAGES = `FIXED_FMA_STAGES,
    parameter int W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    input  logic [W-1:0]       in_bias,
    input  logic               stall,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_dot,
    output logic [W-1:0]       fma_a,
    output logic [W-1:0]       fma_b,
    output logic [W-1:0]       fma_c,
    output logic               fma_stall,
    input  logic [W-1:0]       fma_q
);
`ifdef GFX_DOT_BIAS_EN
    localparam bit bias_en = 1'b1;
`else
    localparam bit bias_en = 1'b0;
`endif
    localparam int lw = $clog2(LANES + 1);
    localparam int cw = $clog2(STAGES + 1);
    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_issue = 2'd1;
    localparam logic [1:0] st_wait  = 2'd2;
    localparam logic [1:0] st_done  = 2'd3;
    logic [1:0]         state;
    logic [lw-1:0]      lane;
    logic [cw-1:0]      cnt;
    logic [W-1:0]       acc;
    logic [LANES*W-1:0] a_sh;
    logic [LANES*W-1:0] b_sh;
    // captured vectors shift down one lane per completed FMA, so the current lane is always at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
            lane  <= '0;
            cnt   <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else if (!stall) begin
            case (state)
                st_idle: if (in_valid) begin
                    a_sh  <= in_a;
                    b_sh  <= in_b;
                    acc   <= bias_en ? in_bias : '0;
                    lane  <= '0;
                    state <= st_issue;
                end
                st_issue: begin
                    cnt   <= cw'(1);
                    state <= st_wait;
                end
                st_wait: if (cnt == cw'(STAGES)) begin
                    acc   <= fma_q;
                    lane  <= lane + 1'b1;
                    a_sh  <= a_sh >> W;
                    b_sh  <= b_sh >> W;
                    state <= (lane == lw'(LANES - 1)) ? st_done : st_issue;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: if (out_ready) state <= st_idle;
            endcase
        end
    end
    assign in_ready  = state == st_idle;
    assign out_valid = state == st_done;
    assign out_dot   = out_valid ? acc : '0;
    assign fma_a     = a_sh[W-1:0];
    assign fma_b     = b_sh[W-1:0];
    assign fma_c     = acc;
    assign fma_stall = stall;
endmodule
